// File: rtl/moore_det_pkg.sv
// ============================================================================
// moore_det_pkg : shared constants and helpers for the programmable detector
// Rev 1.0
// ============================================================================
`default_nettype none

package moore_det_pkg;

  localparam int              PAT_W_DEF       = 4;
  localparam logic [3:0]      PAT_DEFAULT_DEF = 4'b1101;
  localparam int              CNT_W_DEF       = 8;

  localparam logic            MODE_OVERLAP    = 1'b1;
  localparam logic            MODE_NONOVL     = 1'b0;

  // Width needed to hold a matched-prefix length of 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/moore_det_next.sv
// ============================================================================
// moore_det_next : combinational next-state (longest prefix that is a suffix)
// Rev 1.0
// ============================================================================
`default_nettype none

module moore_det_next
  import moore_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] s,
  input  logic             b,
  input  logic             overlap,
  output logic [LEN_W-1:0] s_next
);

  logic [LEN_W:0]   s_p1;
  logic [PAT_W-1:0] hit;

  assign s_p1 = {1'b0, s} + (LEN_W+1)'(1);

  // Candidate k: the last k bits of {pattern[0..s-1], b} equal pattern[0..k-1].
  // The older k-1 bits are pattern[s+1-k .. s-1], obtained by shifting.
  for (genvar k = 1; k <= PAT_W; k++) begin : g_k
    localparam logic [LEN_W:0]   K    = (LEN_W+1)'(k);
    localparam logic [PAT_W-1:0] MASK = PAT_W'((64'd1 << (k - 1)) - 64'd1);

    logic [PAT_W-1:0] suffix;

    assign suffix   = pattern >> (s_p1 - K);
    assign hit[k-1] = (K <= s_p1) && (K <= {1'b0, len}) &&
                      (pattern[k-1] == b) &&
                      (((suffix ^ pattern) & MASK) == '0);
  end

  always_comb begin
    s_next = '0;
    if ((s == len) && (overlap == MODE_NONOVL)) begin
      s_next = (b == pattern[0]) ? LEN_W'(1) : '0;
    end else begin
      for (int i = 0; i < PAT_W; i++) begin
        if (hit[i]) s_next = LEN_W'(i + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/moore_seq_detector.sv
// ============================================================================
// moore_seq_detector : programmable Moore serial pattern detector with counter
// Optional match counter enabled by MOORE_DET_CNT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module moore_seq_detector
  import moore_det_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_DEF),
  parameter int               CNT_W       = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic [len_w(PAT_W)-1:0]   cfg_len,
  input  logic                      cfg_overlap,
  input  logic                      in_valid,
  input  logic                      in,
  output logic                      out,
  output logic [len_w(PAT_W)-1:0]   state_o,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      cnt_sat
);

  localparam int               LEN_W   = len_w(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] state_q, state_d;
  logic             overlap_q, overlap_d;
  logic             out_q, out_d;
  logic [LEN_W-1:0] step_s;
  logic [LEN_W-1:0] cfg_len_clamped;

  moore_det_next #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_next (
    .pattern (pattern_q),
    .len     (len_q),
    .s       (state_q),
    .b       (in),
    .overlap (overlap_q),
    .s_next  (step_s)
  );

  always_comb begin
    cfg_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      cfg_len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      cfg_len_clamped = LEN_MAX;
    end
  end

  // A config write wins over a coincident input bit, which is dropped.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    state_d   = state_q;
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len_clamped;
      overlap_d = cfg_overlap;
      state_d   = '0;
    end else if (in_valid) begin
      state_d   = step_s;
    end
    out_d = (state_d == len_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_q <= PAT_DEFAULT;
      len_q     <= LEN_MAX;
      overlap_q <= MODE_OVERLAP;
      state_q   <= '0;
      out_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      state_q   <= state_d;
      out_q     <= out_d;
    end
  end

  assign out     = out_q;
  assign state_o = state_q;

`ifdef MOORE_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             match_step;

  assign match_step = in_valid && (step_s == len_q);

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (cfg_we) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (match_step && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sat_d = sat_q | (cnt_d == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

`default_nettype wire
